alu_rsp_collector: RTL and testbench
====================================

ALU_RSP_COLLECTOR -- requirements
Module: alu_rsp_collector

Interface
REQ-001 Parameter WIDTH, default 32, result width; SHALL match the ALU datapath width.
REQ-002 Parameter DEPTH, default 4, FIFO entries; SHALL be a power of two and >= 4.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 issue  input  1  pulse; one ALU request accepted upstream this cycle.
REQ-006 in_valid  input  1  ALU response valid; no backpressure path to the ALU.
REQ-007 in_result  input  WIDTH  ALU result.
REQ-008 in_zero, in_neg, in_ovf, in_carry  input  1 each  ALU flags.
REQ-009 credit_ok  output  1  upstream may issue a request this cycle.
REQ-010 out_valid  output  1  head entry available.
REQ-011 out_ready  input  1  consumer accepts head.
REQ-012 out_result  output  WIDTH  head result.
REQ-013 out_flags  output  4  head flags {carry, ovf, neg, zero}.
REQ-014 count  output  $clog2(DEPTH)+1  stored entries.
REQ-015 ovf_sticky, carry_sticky  output  1 each  accumulated flags.
REQ-016 clr_sticky  input  1  clears both sticky flags.
REQ-017 err_overflow  output  1  sticky; response dropped.
REQ-018 rsp_cnt  output  16  accepted-response counter.

Function
REQ-019 Push = in_valid; pop = out_valid && out_ready; storage SHALL be a circular FIFO with wrapping read and write pointers.
REQ-020 Entry SHALL be {in_carry, in_ovf, in_neg, in_zero, in_result}, captured on the push edge.
REQ-021 Output SHALL be first-word-fall-through: an entry pushed at edge N SHALL present out_valid=1 from cycle N+1.
REQ-022 out_valid SHALL equal (count != 0); out_result/out_flags SHALL be the head entry whenever out_valid=1, and are don't-care otherwise.
REQ-023 Push when not full: accepted; count +1, unless a pop occurs in the same cycle (count unchanged).
REQ-024 Push when full with a same-cycle pop: accepted; count stays DEPTH; ordering preserved.
REQ-025 Push when full without a pop: entry dropped; count unchanged; err_overflow set to 1 and held until reset.
REQ-026 Pop when empty SHALL be impossible, since out_valid=0 then.
REQ-027 inflight counter (0..DEPTH): +1 on issue, -1 on in_valid, unchanged when both occur in the same cycle; saturates and never wraps.
REQ-028 credit_ok SHALL be combinational and equal (count + inflight < DEPTH), which guarantees no drop for a compliant upstream.
REQ-029 ovf_sticky and carry_sticky SHALL set on an accepted push whose ovf or carry bit is 1.
REQ-030 clr_sticky SHALL clear both sticky flags on the next edge; when a set and a clear occur in the same cycle, set SHALL win.
REQ-031 rsp_cnt SHALL increment by 1 on each accepted push and wrap from 0xFFFF to 0x0000.
REQ-032 Dropped pushes SHALL affect neither the sticky flags nor rsp_cnt.

Reset
REQ-033 On rst=1, asynchronously and at any time including mid-transfer, the block SHALL drive: pointers=0, count=0, inflight=0, out_valid=0, credit_ok=1, ovf_sticky=0, carry_sticky=0, err_overflow=0, rsp_cnt=0.
REQ-034 FIFO storage contents need not be reset.
REQ-035 After rst deasserts, in_valid SHALL be honoured from the first rising edge.

Verification
REQ-036 Single pass-through: push result=0x00000005, flags=0000, out_ready=1 -> out_valid=1 on the next cycle with out_result=0x5; count returns to 0; rsp_cnt=1.
REQ-037 Fill then drain, DEPTH=4, out_ready=0: push 0xA,0xB,0xC,0xD -> count=4, credit_ok=0; then out_ready=1 -> pops in order A,B,C,D; count=0.
REQ-038 Full with simultaneous push and pop: push 0xE while popping 0xA -> count stays 4; drain order B,C,D,E; err_overflow=0.
REQ-039 Overflow: full, push 0xF with out_ready=0 -> 0xF absent on drain; err_overflow=1; rsp_cnt=4.
REQ-040 Credit check: 3 entries stored, issue=1 -> inflight=1, credit_ok=0; issue and in_valid in the same cycle -> inflight unchanged.
REQ-041 Sticky behaviour: push with ovf=1 and clr_sticky=1 in the same cycle -> ovf_sticky=1; then clr_sticky alone -> 0. Assert rst mid-drain -> all REQ-033 values appear immediately.

Source files
------------

// File: rtl/alu_rsp_collector.sv
// alu_rsp_collector: collects ALU responses into a first-word-fall-through FIFO,
// hands out issue credits so a compliant upstream never overruns it, and keeps
// sticky overflow/carry flags, a sticky drop error and an accepted-response count.
module alu_rsp_collector #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     issue,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_result,
    input  logic                     in_zero,
    input  logic                     in_neg,
    input  logic                     in_ovf,
    input  logic                     in_carry,
    output logic                     credit_ok,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_result,
    output logic [3:0]               out_flags,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf_sticky,
    output logic                     carry_sticky,
    input  logic                     clr_sticky,
    output logic                     err_overflow,
    output logic [15:0]              rsp_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = WIDTH + 4;

    // Entry layout: {carry, ovf, neg, zero, result}
    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          ovf_sticky_q, ovf_sticky_d;
    logic          carry_sticky_q, carry_sticky_d;
    logic          err_overflow_q, err_overflow_d;
    logic [15:0]   rsp_cnt_q, rsp_cnt_d;

    logic full;
    logic pop;
    logic push_acc;
    logic drop;

    assign full     = (count_q == CW'(DEPTH));
    assign pop      = out_valid && out_ready;
    // A full FIFO still accepts when the head leaves in the same cycle.
    assign push_acc = in_valid && (!full || pop);
    assign drop     = in_valid && full && !pop;

    assign out_valid    = (count_q != '0);
    assign out_result   = mem[rd_ptr_q][WIDTH-1:0];
    assign out_flags    = mem[rd_ptr_q][EW-1:WIDTH];
    assign count        = count_q;
    assign credit_ok    = ({1'b0, count_q} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
    assign ovf_sticky   = ovf_sticky_q;
    assign carry_sticky = carry_sticky_q;
    assign err_overflow = err_overflow_q;
    assign rsp_cnt      = rsp_cnt_q;

    // Next-state computation for pointers, occupancy, credits and status flags.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        inflight_d     = inflight_q;
        ovf_sticky_d   = ovf_sticky_q;
        carry_sticky_d = carry_sticky_q;
        err_overflow_d = err_overflow_q;
        rsp_cnt_d      = rsp_cnt_q;

        // Power-of-two depth lets the pointers wrap by plain overflow.
        if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;

        if (push_acc && !pop)      count_d = count_q + 1'b1;
        else if (!push_acc && pop) count_d = count_q - 1'b1;

        // Saturating credit tracker; simultaneous issue and response cancel out.
        if (issue && !in_valid && inflight_q != CW'(DEPTH))
            inflight_d = inflight_q + 1'b1;
        else if (in_valid && !issue && inflight_q != '0)
            inflight_d = inflight_q - 1'b1;

        // Clear first so a same-cycle set overrides it.
        if (clr_sticky) begin
            ovf_sticky_d   = 1'b0;
            carry_sticky_d = 1'b0;
        end
        if (push_acc && in_ovf)   ovf_sticky_d   = 1'b1;
        if (push_acc && in_carry) carry_sticky_d = 1'b1;

        if (drop)     err_overflow_d = 1'b1;
        if (push_acc) rsp_cnt_d      = rsp_cnt_q + 16'd1;
    end

    // Control and status registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            inflight_q     <= '0;
            ovf_sticky_q   <= 1'b0;
            carry_sticky_q <= 1'b0;
            err_overflow_q <= 1'b0;
            rsp_cnt_q      <= '0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            inflight_q     <= inflight_d;
            ovf_sticky_q   <= ovf_sticky_d;
            carry_sticky_q <= carry_sticky_d;
            err_overflow_q <= err_overflow_d;
            rsp_cnt_q      <= rsp_cnt_d;
        end
    end

    // Entry storage written on accepted pushes.
    // NOTE: storage has no reset; out_valid is derived from count, so stale contents are never presented as valid.
    always_ff @(posedge clk) begin
        if (push_acc) mem[wr_ptr_q] <= {in_carry, in_ovf, in_neg, in_zero, in_result};
    end

endmodule

// File: tb/tb_alu_rsp_collector.sv
// Directed testbench for alu_rsp_collector (WIDTH=32, DEPTH=4).
module tb_alu_rsp_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue;
    logic        in_valid;
    logic [31:0] in_result;
    logic        in_zero, in_neg, in_ovf, in_carry;
    logic        credit_ok;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [3:0]  out_flags;
    logic [2:0]  count;
    logic        ovf_sticky, carry_sticky;
    logic        clr_sticky;
    logic        err_overflow;
    logic [15:0] rsp_cnt;

    int checks = 0;
    int errors = 0;

    alu_rsp_collector #(.WIDTH(32), .DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue        (issue),
        .in_valid     (in_valid),
        .in_result    (in_result),
        .in_zero      (in_zero),
        .in_neg       (in_neg),
        .in_ovf       (in_ovf),
        .in_carry     (in_carry),
        .credit_ok    (credit_ok),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .count        (count),
        .ovf_sticky   (ovf_sticky),
        .carry_sticky (carry_sticky),
        .clr_sticky   (clr_sticky),
        .err_overflow (err_overflow),
        .rsp_cnt      (rsp_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push one entry (result only, flags clear) over one cycle.
    task automatic push(input logic [31:0] v);
        in_valid  = 1'b1;
        in_result = v;
        step();
        in_valid  = 1'b0;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".count"},    64'(count),        64'd0);
        check({tag, ".valid"},    64'(out_valid),    64'd0);
        check({tag, ".credit"},   64'(credit_ok),    64'd1);
        check({tag, ".ovf_st"},   64'(ovf_sticky),   64'd0);
        check({tag, ".carry_st"}, 64'(carry_sticky), 64'd0);
        check({tag, ".err"},      64'(err_overflow), 64'd0);
        check({tag, ".rsp_cnt"},  64'(rsp_cnt),      64'd0);
        check({tag, ".inflight"}, 64'(dut.inflight_q), 64'd0);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    logic [31:0] exp_q [$];

    initial begin
        rst = 1'b1; issue = 1'b0; in_valid = 1'b0; in_result = '0;
        in_zero = 1'b0; in_neg = 1'b0; in_ovf = 1'b0; in_carry = 1'b0;
        out_ready = 1'b0; clr_sticky = 1'b0;
        #3;
        check_reset_state("reset");
        step();
        rst = 1'b0;

        // Single pass-through
        out_ready = 1'b1;
        push(32'h5);
        check("pass.valid",  64'(out_valid),  64'd1);
        check("pass.result", 64'(out_result), 64'h5);
        check("pass.flags",  64'(out_flags),  64'h0);
        step();
        check("pass.count",   64'(count),   64'd0);
        check("pass.rsp_cnt", 64'(rsp_cnt), 64'd1);

        // Fill then drain in order
        out_ready = 1'b0;
        push(32'hA); push(32'hB); push(32'hC); push(32'hD);
        check("fill.count",  64'(count),     64'd4);
        check("fill.credit", 64'(credit_ok), 64'd0);
        out_ready = 1'b1;
        exp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        foreach (exp_q[i]) begin
            check($sformatf("drain%0d", i), 64'(out_result), 64'(exp_q[i]));
            step();
        end
        check("drain.count", 64'(count), 64'd0);

        // Full with simultaneous push and pop
        out_ready = 1'b0;
        push(32'hA); push(32'hB); push(32'hC); push(32'hD);
        out_ready = 1'b1;
        in_valid = 1'b1; in_result = 32'hE;
        check("fullpp.head", 64'(out_result), 64'hA);
        step();
        in_valid = 1'b0;
        check("fullpp.count", 64'(count),        64'd4);
        check("fullpp.err",   64'(err_overflow), 64'd0);
        exp_q = '{32'hB, 32'hC, 32'hD, 32'hE};
        foreach (exp_q[i]) begin
            check($sformatf("fullpp.drain%0d", i), 64'(out_result), 64'(exp_q[i]));
            step();
        end
        check("fullpp.empty", 64'(out_valid), 64'd0);

        // Overflow drop (fresh counters); dropped entry carries ovf which must be ignored
        out_ready = 1'b0;
        pulse_reset();
        push(32'hA); push(32'hB); push(32'hC); push(32'hD);
        in_ovf = 1'b1;
        push(32'hF);
        in_ovf = 1'b0;
        check("ovfl.count",   64'(count),        64'd4);
        check("ovfl.err",     64'(err_overflow), 64'd1);
        check("ovfl.rsp_cnt", 64'(rsp_cnt),      64'd4);
        check("ovfl.ovf_st",  64'(ovf_sticky),   64'd0);
        out_ready = 1'b1;
        exp_q = '{32'hA, 32'hB, 32'hC, 32'hD};
        foreach (exp_q[i]) begin
            check($sformatf("ovfl.drain%0d", i), 64'(out_result), 64'(exp_q[i]));
            step();
        end
        check("ovfl.f_absent", 64'(out_valid),    64'd0);
        check("ovfl.err_hold", 64'(err_overflow), 64'd1);

        // Credit accounting
        out_ready = 1'b0;
        push(32'h1); push(32'h2); push(32'h3);
        check("cred.3.credit", 64'(credit_ok), 64'd1);
        issue = 1'b1;
        step();
        issue = 1'b0;
        check("cred.inflight1", 64'(dut.inflight_q), 64'd1);
        check("cred.credit0",   64'(credit_ok),      64'd0);
        issue = 1'b1; in_valid = 1'b1; in_result = 32'h4;
        step();
        issue = 1'b0; in_valid = 1'b0;
        check("cred.same.inflight", 64'(dut.inflight_q), 64'd1);
        check("cred.same.count",    64'(count),          64'd4);
        out_ready = 1'b1; in_valid = 1'b1; in_result = 32'h5;
        step();
        in_valid = 1'b0;
        check("cred.rsp.inflight", 64'(dut.inflight_q), 64'd0);
        check("cred.rsp.count",    64'(count),          64'd4);
        repeat (4) step();
        check("cred.empty.credit", 64'(credit_ok), 64'd1);

        // Sticky flags: set beats clear, then clear alone
        out_ready = 1'b0;
        in_ovf = 1'b1; clr_sticky = 1'b1;
        push(32'h21);
        in_ovf = 1'b0; clr_sticky = 1'b0;
        check("sticky.set_wins", 64'(ovf_sticky),   64'd1);
        check("sticky.carry0",   64'(carry_sticky), 64'd0);
        clr_sticky = 1'b1;
        step();
        clr_sticky = 1'b0;
        check("sticky.cleared", 64'(ovf_sticky), 64'd0);
        in_carry = 1'b1;
        push(32'h22);
        in_carry = 1'b0;
        check("sticky.carry1", 64'(carry_sticky), 64'd1);
        check("head.flags",    64'(out_flags),    64'b0100);
        out_ready = 1'b1;
        step();
        check("head2.flags",  64'(out_flags),  64'b1000);
        check("head2.result", 64'(out_result), 64'h22);

        // Asynchronous reset mid-drain, away from any edge
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("async_rst");
        out_ready = 1'b0;
        step();
        rst = 1'b0;
        push(32'h33);
        check("post_rst.count",  64'(count),      64'd1);
        check("post_rst.result", 64'(out_result), 64'h33);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
